axis_pkt_fifo: RTL and testbench



---
 rtl/axis_pkt_fifo_if.sv | 13 +
 rtl/axis_pkt_fifo.sv | 103 ++++++++++
 tb/tb_axis_pkt_fifo.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream bundle carrying data, byte enables and end-of-packet between one master and one slave.
interface axis_pkt_fifo_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic                    tvalid;
   logic                    tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with tkeep/tlast sidebands, occupancy/packet status and optional store-and-forward.
// In packet mode an oversize frame (pkt_count==0 while full) switches to cut-through until its tlast leaves.
module axis_pkt_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter bit PKT_MODE   = 1'b0
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   axis_pkt_fifo_if.slave         s_axis,
   axis_pkt_fifo_if.master        m_axis,
   output logic [$clog2(DEPTH):0] count,
   output logic [$clog2(DEPTH):0] pkt_count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int KW = DATA_WIDTH / 8;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] memData [DEPTH];
   logic [KW-1:0]         memKeep [DEPTH];
   logic                  memLast [DEPTH];

   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] pktCount_q, pktCount_d;
   logic          readyEn_q;
   logic          oversize_q, oversize_d;
   logic          push, pop, pushLast, popLast;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign pkt_count = pktCount_q;

   // No write-through when full: a same-cycle pop never opens the input.
   assign s_axis.tready = readyEn_q && !full;
   assign m_axis.tvalid = !empty && (!PKT_MODE || (pktCount_q != '0) || oversize_q);
   assign m_axis.tdata  = memData[rdPtr_q];
   assign m_axis.tkeep  = memKeep[rdPtr_q];
   assign m_axis.tlast  = memLast[rdPtr_q];

   assign push     = s_axis.tvalid && s_axis.tready;
   assign pop      = m_axis.tvalid && m_axis.tready;
   assign pushLast = push && s_axis.tlast;
   assign popLast  = pop && memLast[rdPtr_q];

   always_comb begin
      wrPtr_d    = push ? wrPtr_q + AW'(1) : wrPtr_q;
      rdPtr_d    = pop ? rdPtr_q + AW'(1) : rdPtr_q;
      count_d    = count_q;
      pktCount_d = pktCount_q;
      oversize_d = 1'b0;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
      if (pushLast && !popLast) begin
         pktCount_d = pktCount_q + CW'(1);
      end else if (!pushLast && popLast) begin
         pktCount_d = pktCount_q - CW'(1);
      end
      if (PKT_MODE) begin
         oversize_d = oversize_q;
         if (popLast) begin
            oversize_d = 1'b0;
         end else if (full && (pktCount_q == '0)) begin
            oversize_d = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         pktCount_q <= '0;
         oversize_q <= 1'b0;
         readyEn_q  <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         pktCount_q <= pktCount_d;
         oversize_q <= oversize_d;
         readyEn_q  <= 1'b1;
      end
   end

   // Storage is deliberately not reset; the pointers alone define what is valid.
   always_ff @(posedge aclk) begin
      if (push) begin
         memData[wrPtr_q] <= s_axis.tdata;
         memKeep[wrPtr_q] <= s_axis.tkeep;
         memLast[wrPtr_q] <= s_axis.tlast;
      end
   end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: one plain-FIFO instance and one store-and-forward instance, DEPTH=16.
module tb_axis_pkt_fifo;
   logic       clk = 1'b0;
   logic       aresetn;
   logic [4:0] count0, pkt0, count1, pkt1;
   logic       full0, empty0, full1, empty1;
   int         checks = 0;
   int         errors = 0;

   axis_pkt_fifo_if #(.DATA_WIDTH(32)) s0 ();
   axis_pkt_fifo_if #(.DATA_WIDTH(32)) m0 ();
   axis_pkt_fifo_if #(.DATA_WIDTH(32)) s1 ();
   axis_pkt_fifo_if #(.DATA_WIDTH(32)) m1 ();

   axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PKT_MODE(1'b0)) dut0 (
      .aclk(clk), .aresetn(aresetn), .s_axis(s0), .m_axis(m0),
      .count(count0), .pkt_count(pkt0), .full(full0), .empty(empty0)
   );

   axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PKT_MODE(1'b1)) dut1 (
      .aclk(clk), .aresetn(aresetn), .s_axis(s1), .m_axis(m1),
      .count(count1), .pkt_count(pkt1), .full(full1), .empty(empty1)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit sel, input logic valid, input logic [31:0] data,
                                input logic [3:0] keep, input logic last, input logic mready);
      if (!sel) begin
         s0.tvalid = valid; s0.tdata = data; s0.tkeep = keep; s0.tlast = last; m0.tready = mready;
      end else begin
         s1.tvalid = valid; s1.tdata = data; s1.tkeep = keep; s1.tlast = last; m1.tready = mready;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      aresetn = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      repeat (3) begin
         tick();
         checkOutput("rst_tready0", s0.tready, 0);
         checkOutput("rst_tvalid0", m0.tvalid, 0);
         checkOutput("rst_count0", count0, 0);
         checkOutput("rst_pkt0", pkt0, 0);
         checkOutput("rst_empty0", empty0, 1);
         checkOutput("rst_full0", full0, 0);
         checkOutput("rst_tready1", s1.tready, 0);
         checkOutput("rst_tvalid1", m1.tvalid, 0);
         checkOutput("rst_count1", count1, 0);
         checkOutput("rst_pkt1", pkt1, 0);
         checkOutput("rst_empty1", empty1, 1);
      end
      aresetn = 1'b1;
      #1;
      checkOutput("rel_tready_lat", s0.tready, 0);
      tick();
      checkOutput("rel_tready0", s0.tready, 1);
      checkOutput("rel_tready1", s1.tready, 1);
      checkOutput("rel_tvalid0", m0.tvalid, 0);
      checkOutput("rel_empty0", empty0, 1);
   endtask

   logic [36:0] q[$];
   int          pktModel;
   int          beatsSent, beatsRecv, frameLeft, j, r;
   logic        sv, mr, curLast, expValid, pushNow, popNow;
   logic [31:0] curData;
   logic [3:0]  curKeep;

   initial begin
      doReset();

      // Plain FIFO: fill to 16 with the output stalled, then drain in order.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 32'(i), 4'hF, 1'b0, 1'b0);
         #1;
         checkOutput("fill_count", count0, i);
         checkOutput("fill_tready", s0.tready, 1);
         tick();
      end
      applyStimulus(1'b0, 1'b1, 32'h99, 4'hF, 1'b0, 1'b0);
      #1;
      checkOutput("full_flag", full0, 1);
      checkOutput("full_tready", s0.tready, 0);
      checkOutput("full_count", count0, 16);
      tick();
      checkOutput("full_17th_rejected", count0, 16);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
         #1;
         checkOutput("drain_tvalid", m0.tvalid, 1);
         checkOutput("drain_data", m0.tdata, i);
         if (i == 0) checkOutput("drain_tready_still_low", s0.tready, 0);
         if (i == 1) checkOutput("drain_tready_back", s0.tready, 1);
         tick();
      end
      checkOutput("drain_empty", empty0, 1);
      checkOutput("drain_count", count0, 0);
      checkOutput("drain_tvalid_low", m0.tvalid, 0);

      // Continuous streaming through the plain FIFO wraps the pointers several times.
      for (int k = 0; k < 100; k++) begin
         applyStimulus(1'b0, 1'b1, 32'(100 + k), 4'hF, 1'b0, 1'b1);
         #1;
         checkOutput("stream_count", count0, (k == 0) ? 0 : 1);
         if (k > 0) begin
            checkOutput("stream_tvalid", m0.tvalid, 1);
            checkOutput("stream_data", m0.tdata, 100 + k - 1);
         end
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      checkOutput("stream_last_data", m0.tdata, 199);
      tick();
      checkOutput("stream_empty", empty0, 1);

      // Store-and-forward: nothing leaves until the tlast beat is stored.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(8'hA0 + i), (i == 4) ? 4'h3 : 4'hF, i == 4, 1'b1);
         #1;
         checkOutput("sf_hold_tvalid", m1.tvalid, 0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
         #1;
         if (i == 0) checkOutput("sf_pkt_count", pkt1, 1);
         checkOutput("sf_tvalid", m1.tvalid, 1);
         checkOutput("sf_data", m1.tdata, 8'hA0 + i);
         checkOutput("sf_keep", m1.tkeep, (i == 4) ? 4'h3 : 4'hF);
         checkOutput("sf_last", m1.tlast, i == 4);
         tick();
      end
      checkOutput("sf_pkt_after", pkt1, 0);
      checkOutput("sf_empty_after", empty1, 1);

      // Oversize: 20-beat frame fills the FIFO with no complete packet, forcing cut-through.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, 32'(12'h200 + i), 4'hF, 1'b0, 1'b0);
         #1;
         checkOutput("ovs_hold_tvalid", m1.tvalid, 0);
         tick();
      end
      applyStimulus(1'b1, 1'b1, 32'h210, 4'hF, 1'b0, 1'b0);
      #1;
      checkOutput("ovs_full", full1, 1);
      checkOutput("ovs_pkt_zero", pkt1, 0);
      checkOutput("ovs_tvalid_not_yet", m1.tvalid, 0);
      checkOutput("ovs_tready_low", s1.tready, 0);
      tick();
      j = 16;
      r = 0;
      for (int c = 0; c < 100 && r < 20; c++) begin
         applyStimulus(1'b1, j < 20, 32'(12'h200 + j), 4'hF, j == 19, 1'b1);
         #1;
         if (c == 0) checkOutput("ovs_tvalid_rise", m1.tvalid, 1);
         pushNow = s1.tvalid && s1.tready;
         popNow  = m1.tvalid;
         if (popNow) begin
            checkOutput("ovs_data", m1.tdata, 12'h200 + r);
            checkOutput("ovs_last", m1.tlast, r == 19);
         end
         tick();
         if (pushNow) j++;
         if (popNow) r++;
      end
      checkOutput("ovs_delivered", r, 20);
      checkOutput("ovs_empty", empty1, 1);
      applyStimulus(1'b1, 1'b1, 32'h300, 4'hF, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      checkOutput("ovs_cleared_count", count1, 1);
      checkOutput("ovs_cleared_hold", m1.tvalid, 0);

      // Reset with a partial frame stored discards it.
      doReset();

      // Random valid/ready on the packet-mode instance against a queue model.
      q.delete();
      pktModel  = 0;
      beatsSent = 0;
      beatsRecv = 0;
      frameLeft = $urandom_range(1, 8);
      curData   = $urandom;
      curKeep   = 4'($urandom);
      for (int c = 0; c < 20000 && beatsRecv < 1000; c++) begin
         sv      = ($urandom_range(0, 1) == 1) && (beatsSent < 1000);
         mr      = ($urandom_range(0, 1) == 1);
         curLast = (frameLeft == 1) || (beatsSent == 999);
         applyStimulus(1'b1, sv, curData, curKeep, curLast, mr);
         #1;
         expValid = (q.size() > 0) && (pktModel > 0);
         checkOutput("rnd_count", count1, q.size());
         checkOutput("rnd_pkt", pkt1, pktModel);
         checkOutput("rnd_tvalid", m1.tvalid, expValid);
         checkOutput("rnd_tready", s1.tready, q.size() < 16);
         if (expValid) checkOutput("rnd_beat", {m1.tlast, m1.tkeep, m1.tdata}, q[0]);
         pushNow = sv && (q.size() < 16);
         popNow  = expValid && mr;
         tick();
         if (popNow) begin
            if (q[0][36]) pktModel--;
            void'(q.pop_front());
            beatsRecv++;
         end
         if (pushNow) begin
            q.push_back({curLast, curKeep, curData});
            if (curLast) begin
               pktModel++;
               frameLeft = $urandom_range(1, 8);
            end else begin
               frameLeft--;
            end
            beatsSent++;
            curData = $urandom;
            curKeep = 4'($urandom);
         end
      end
      checkOutput("rnd_all_received", beatsRecv, 1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
